// File: rtl/ppm_pkg.sv
// Shared types and helpers for the 4-PPM frame decoder.
package ppm_pkg;

  // Decoder FSM states.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ALIGN = 2'd1,
    RX    = 2'd2
  } state_e;

  localparam int PPM_SLOTS     = 4;
  localparam int BITS_PER_SYM  = 2;
  localparam int SYMS_PER_BYTE = 4;

  // Index of the set bit of a one-hot slot vector (0 for anything else).
  function automatic logic [1:0] onehot_to_dibit(input logic [3:0] oh);
    logic [1:0] r;
    case (oh)
      4'b0010: r = 2'd1;
      4'b0100: r = 2'd2;
      4'b1000: r = 2'd3;
      default: r = 2'd0;
    endcase
    return r;
  endfunction

  // True when exactly one slot carried a pulse.
  function automatic logic is_onehot(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

endpackage

// File: rtl/ppm4_slot_timer.sv
// Slot/symbol timing for the 4-PPM receiver: counts clk16 cycles within a
// slot, slots within a symbol and symbols within a byte. Counters sit at
// zero whenever run_i is low, so the first RX cycle is slot 0, cycle 0.
module ppm4_slot_timer
  import ppm_pkg::*;
#(
  parameter int SLOT_CLKS = 8
) (
  input  logic       clk16,
  input  logic       rst_n,
  input  logic       run_i,
  output logic [1:0] slot_idx_o,
  output logic [1:0] sym_idx_o,
  output logic       mid_o,
  output logic       sym_end_o
);

  localparam int CW = (SLOT_CLKS > 1) ? $clog2(SLOT_CLKS) : 1;
  localparam logic [CW-1:0] SLOT_LAST = CW'(SLOT_CLKS - 1);
  localparam logic [CW-1:0] SLOT_MID  = CW'(SLOT_CLKS / 2);

  logic [CW-1:0] slot_cnt_q, slot_cnt_d;
  logic [1:0]    slot_idx_q, slot_idx_d;
  logic [1:0]    sym_idx_q,  sym_idx_d;

  // Advance the cycle/slot/symbol counters while running, else park at zero.
  always_comb begin
    slot_cnt_d = slot_cnt_q;
    slot_idx_d = slot_idx_q;
    sym_idx_d  = sym_idx_q;
    if (!run_i) begin
      slot_cnt_d = '0;
      slot_idx_d = 2'd0;
      sym_idx_d  = 2'd0;
    end else if (slot_cnt_q == SLOT_LAST) begin
      slot_cnt_d = '0;
      slot_idx_d = slot_idx_q + 2'd1;
      if (slot_idx_q == 2'(PPM_SLOTS - 1)) begin
        sym_idx_d = sym_idx_q + 2'd1;
      end
    end else begin
      slot_cnt_d = slot_cnt_q + CW'(1);
    end
  end

  // Counter registers.
  always_ff @(posedge clk16 or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt_q <= '0;
      slot_idx_q <= 2'd0;
      sym_idx_q  <= 2'd0;
    end else begin
      slot_cnt_q <= slot_cnt_d;
      slot_idx_q <= slot_idx_d;
      sym_idx_q  <= sym_idx_d;
    end
  end

  assign slot_idx_o = slot_idx_q;
  assign sym_idx_o  = sym_idx_q;
  assign mid_o      = run_i && (slot_cnt_q == SLOT_MID);
  assign sym_end_o  = run_i && (slot_cnt_q == SLOT_LAST) &&
                      (slot_idx_q == 2'(PPM_SLOTS - 1));

endmodule

// File: rtl/ppm4_frame_decoder.sv
// 4-PPM frame decoder: after an upstream SOF pulse, waits START_DLY cycles,
// then samples each slot at mid-point and turns symbols into dibits, four
// dibits per byte (first symbol in bits [1:0]). An empty symbol ends the
// frame; multi-pulse symbols, partial bytes at EOF and byte overflow are
// errors. byte_valid, eof_rcv_out and frame_err are single-cycle strobes
// with no backpressure: the consumer must take byte_data in the cycle
// byte_valid is high (byte_data itself is held until the next byte).
module ppm4_frame_decoder
  import ppm_pkg::*;
#(
  parameter int SLOT_CLKS = 8,
  parameter int START_DLY = 8,
  parameter int MAX_BYTES = 64
) (
  input  logic       clk16,
  input  logic       rst_n,
  input  logic       Din,
  input  logic       sof_rcv_in,
  output logic [7:0] byte_data,
  output logic       byte_valid,
  output logic       eof_rcv_out,
  output logic       frame_err,
  output logic       busy,
  output logic [6:0] byte_cnt
);

  localparam int DW = $clog2(START_DLY) + 1;
  localparam logic [DW-1:0] DLY_LAST = DW'(START_DLY - 1);
  localparam logic [6:0]    MAX_CNT  = 7'(MAX_BYTES);

  state_e      state_q, state_d;
  logic        din_q;
  logic [DW-1:0] dly_cnt_q, dly_cnt_d;
  logic [3:0]  hits_q, hits_d;
  logic [5:0]  shift_q, shift_d;
  logic [7:0]  byte_data_q, byte_data_d;
  logic [6:0]  byte_cnt_q, byte_cnt_d;
  logic        byte_valid_q, byte_valid_d;
  logic        eof_q, eof_d;
  logic        err_q, err_d;

  logic [1:0]  slot_idx, sym_idx, dibit;
  logic        mid, sym_end, run;

  assign run   = (state_q == RX);
  assign dibit = onehot_to_dibit(hits_q);

  ppm4_slot_timer #(
    .SLOT_CLKS(SLOT_CLKS)
  ) u_slot_timer (
    .clk16     (clk16),
    .rst_n     (rst_n),
    .run_i     (run),
    .slot_idx_o(slot_idx),
    .sym_idx_o (sym_idx),
    .mid_o     (mid),
    .sym_end_o (sym_end)
  );

  // Line conditioning: pulses are active-low on Din, active-high on din_q.
  always_ff @(posedge clk16 or negedge rst_n) begin
    if (!rst_n) din_q <= 1'b0;
    else        din_q <= !Din;
  end

  // Next-state, slot capture, symbol evaluation and byte assembly.
  always_comb begin
    state_d      = state_q;
    dly_cnt_d    = dly_cnt_q;
    hits_d       = hits_q;
    shift_d      = shift_q;
    byte_data_d  = byte_data_q;
    byte_cnt_d   = byte_cnt_q;
    byte_valid_d = 1'b0;
    eof_d        = 1'b0;
    err_d        = 1'b0;
    case (state_q)
      IDLE: begin
        hits_d = 4'd0;
        if (sof_rcv_in) begin
          state_d    = ALIGN;
          dly_cnt_d  = '0;
          byte_cnt_d = 7'd0;
        end
      end
      ALIGN: begin
        hits_d = 4'd0;
        if (dly_cnt_q == DLY_LAST) state_d = RX;
        else                       dly_cnt_d = dly_cnt_q + DW'(1);
      end
      RX: begin
        if (mid) hits_d[slot_idx] = din_q;
        if (sym_end) begin
          hits_d = 4'd0;
          if (hits_q == 4'd0) begin
            // Empty symbol: end of frame; a partial byte is an error.
            eof_d   = 1'b1;
            err_d   = (sym_idx != 2'd0);
            state_d = IDLE;
          end else if (is_onehot(hits_q)) begin
            case (sym_idx)
              2'd0: shift_d[1:0] = dibit;
              2'd1: shift_d[3:2] = dibit;
              2'd2: shift_d[5:4] = dibit;
              default: begin
                if (byte_cnt_q == MAX_CNT) begin
                  // Overflow: drop the byte and re-arm upstream.
                  err_d   = 1'b1;
                  eof_d   = 1'b1;
                  state_d = IDLE;
                end else begin
                  byte_data_d  = {dibit, shift_q};
                  byte_valid_d = 1'b1;
                  byte_cnt_d   = byte_cnt_q + 7'd1;
                end
              end
            endcase
          end else begin
            // Several pulses in one symbol: coding error.
            err_d   = 1'b1;
            eof_d   = 1'b1;
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers.
  always_ff @(posedge clk16 or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      dly_cnt_q    <= '0;
      hits_q       <= 4'd0;
      shift_q      <= 6'd0;
      byte_data_q  <= 8'd0;
      byte_cnt_q   <= 7'd0;
      byte_valid_q <= 1'b0;
      eof_q        <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      dly_cnt_q    <= dly_cnt_d;
      hits_q       <= hits_d;
      shift_q      <= shift_d;
      byte_data_q  <= byte_data_d;
      byte_cnt_q   <= byte_cnt_d;
      byte_valid_q <= byte_valid_d;
      eof_q        <= eof_d;
      err_q        <= err_d;
    end
  end

  assign byte_data   = byte_data_q;
  assign byte_valid  = byte_valid_q;
  assign eof_rcv_out = eof_q;
  assign frame_err   = err_q;
  assign busy        = (state_q != IDLE);
  assign byte_cnt    = byte_cnt_q;

endmodule

// File: tb/tb_ppm4_frame_decoder.sv
// Directed bench for ppm4_frame_decoder: one default instance and one with
// MAX_BYTES=2 share the same stimulus.
module tb_ppm4_frame_decoder;

  localparam int SLOT_CLKS = 8;
  localparam int START_DLY = 8;

  // ---------------- clock / reset ----------------
  logic clk16 = 1'b0;
  logic rst_n;
  logic Din;
  logic sof;
  always #5 clk16 = ~clk16;

  logic [7:0] bd  [2];
  logic       bv  [2];
  logic       eof [2];
  logic       err [2];
  logic       bsy [2];
  logic [6:0] bc  [2];

  ppm4_frame_decoder u_dut (
    .clk16(clk16), .rst_n(rst_n), .Din(Din), .sof_rcv_in(sof),
    .byte_data(bd[0]), .byte_valid(bv[0]), .eof_rcv_out(eof[0]),
    .frame_err(err[0]), .busy(bsy[0]), .byte_cnt(bc[0])
  );

  ppm4_frame_decoder #(.MAX_BYTES(2)) u_dut_max2 (
    .clk16(clk16), .rst_n(rst_n), .Din(Din), .sof_rcv_in(sof),
    .byte_data(bd[1]), .byte_valid(bv[1]), .eof_rcv_out(eof[1]),
    .frame_err(err[1]), .busy(bsy[1]), .byte_cnt(bc[1])
  );

  // ---------------- checking ----------------
  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard / monitor ----------------
  logic [7:0] exp_q[$];
  int cnt_bv[2], cnt_eof[2], cnt_err[2], cnt_both[2];
  int cyc = 0;
  int last_bv_cyc = 0;
  int bv_gap = 0;
  logic pbv[2], peof[2], perr[2];

  always @(posedge clk16) cyc <= cyc + 1;

  // Count strobes, check strobe width and compare bytes of the default DUT.
  always @(negedge clk16) begin
    for (int k = 0; k < 2; k++) begin
      if (bv[k] || eof[k] || err[k])
        check($sformatf("strobe_width%0d", k),
              32'((bv[k] & pbv[k]) | (eof[k] & peof[k]) | (err[k] & perr[k])), 0);
      if (bv[k]) cnt_bv[k]++;
      if (eof[k]) cnt_eof[k]++;
      if (err[k]) cnt_err[k]++;
      if (eof[k] && err[k]) cnt_both[k]++;
      pbv[k]  = bv[k];
      peof[k] = eof[k];
      perr[k] = err[k];
    end
    if (bv[0]) begin
      check("byte_expected", 32'(exp_q.size() != 0), 1);
      if (exp_q.size() != 0) check("byte_data", bd[0], exp_q.pop_front());
      bv_gap      = cyc - last_bv_cyc;
      last_bv_cyc = cyc;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk16);
    #1;
  endtask

  task automatic clear_mon();
    for (int k = 0; k < 2; k++) begin
      cnt_bv[k] = 0; cnt_eof[k] = 0; cnt_err[k] = 0; cnt_both[k] = 0;
    end
  endtask

  task automatic idle(input int n);
    Din = 1'b1;
    sof = 1'b0;
    repeat (n) tick();
  endtask

  task automatic start_frame();
    Din = 1'b1;
    sof = 1'b1;
    tick();
    sof = 1'b0;
    repeat (START_DLY) tick();
  endtask

  // One symbol; m marks the slots carrying a (low) pulse.
  task automatic send_mask(input logic [3:0] m, input bit sof_mid);
    for (int s = 0; s < 4; s++) begin
      for (int c = 0; c < SLOT_CLKS; c++) begin
        Din = !m[s];
        sof = sof_mid && (s == 1) && (c == 2);
        tick();
      end
    end
    Din = 1'b1;
    sof = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit sof_mid);
    logic [1:0] d;
    for (int i = 0; i < 4; i++) begin
      d = b[2*i +: 2];
      send_mask(4'b0001 << d, sof_mid && (i == 1));
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0;
    Din   = 1'b1;
    sof   = 1'b0;
    for (int k = 0; k < 2; k++) begin
      pbv[k] = 1'b0; peof[k] = 1'b0; perr[k] = 1'b0;
    end
    clear_mon();
    repeat (3) tick();
    for (int k = 0; k < 2; k++) begin
      check("rst_byte_data", bd[k], 0);
      check("rst_byte_valid", bv[k], 0);
      check("rst_eof", eof[k], 0);
      check("rst_err", err[k], 0);
      check("rst_busy", bsy[k], 0);
      check("rst_byte_cnt", bc[k], 0);
    end
    rst_n = 1'b1;
    idle(3);

    // Single byte 0x63 (slots 3,0,2,1) then empty symbol.
    clear_mon();
    exp_q.push_back(8'h63);
    start_frame();
    check("t1_busy_in_frame", bsy[0], 1);
    send_byte(8'h63, 1'b0);
    send_mask(4'b0000, 1'b0);
    check("t1_eof_latency", eof[0], 1);
    check("t1_busy_fall", bsy[0], 0);
    idle(4);
    check("t1_bv_cnt", cnt_bv[0], 1);
    check("t1_eof_cnt", cnt_eof[0], 1);
    check("t1_err_cnt", cnt_err[0], 0);
    check("t1_byte_data", bd[0], 8'h63);
    check("t1_byte_cnt", bc[0], 1);

    // Empty symbol as 3rd symbol of a byte: EOF with error, data held.
    clear_mon();
    start_frame();
    send_mask(4'b0010, 1'b0);
    send_mask(4'b0100, 1'b0);
    send_mask(4'b0000, 1'b0);
    idle(4);
    check("t4_bv_cnt", cnt_bv[0], 0);
    check("t4_both_cnt", cnt_both[0], 1);
    check("t4_eof_cnt", cnt_eof[0], 1);
    check("t4_byte_data", bd[0], 8'h63);
    check("t4_byte_cnt", bc[0], 0);
    check("t4_busy", bsy[0], 0);

    // Two bytes 0xA5, 0x00 then EOF.
    clear_mon();
    exp_q.push_back(8'hA5);
    exp_q.push_back(8'h00);
    start_frame();
    send_byte(8'hA5, 1'b0);
    send_byte(8'h00, 1'b0);
    send_mask(4'b0000, 1'b0);
    idle(4);
    check("t2_bv_cnt", cnt_bv[0], 2);
    check("t2_bv_gap", bv_gap, 128);
    check("t2_byte_cnt", bc[0], 2);
    check("t2_eof_cnt", cnt_eof[0], 1);
    check("t2_err_cnt", cnt_err[0], 0);
    check("t2_byte_data", bd[0], 8'h00);

    // Two pulses in one symbol: coding error.
    clear_mon();
    start_frame();
    send_mask(4'b0101, 1'b0);
    idle(4);
    check("t3_both_cnt", cnt_both[0], 1);
    check("t3_err_cnt", cnt_err[0], 1);
    check("t3_bv_cnt", cnt_bv[0], 0);
    check("t3_busy", bsy[0], 0);
    check("t3_byte_data", bd[0], 8'h00);

    // Three bytes: default DUT takes them all, MAX_BYTES=2 DUT overflows.
    clear_mon();
    exp_q.push_back(8'h1B);
    exp_q.push_back(8'h4E);
    exp_q.push_back(8'hC6);
    start_frame();
    send_byte(8'h1B, 1'b0);
    send_byte(8'h4E, 1'b0);
    send_byte(8'hC6, 1'b0);
    send_mask(4'b0000, 1'b0);
    idle(4);
    check("t5_bv_cnt", cnt_bv[0], 3);
    check("t5_eof_cnt", cnt_eof[0], 1);
    check("t5_err_cnt", cnt_err[0], 0);
    check("t5_byte_cnt", bc[0], 3);
    check("t5m_bv_cnt", cnt_bv[1], 2);
    check("t5m_both_cnt", cnt_both[1], 1);
    check("t5m_eof_cnt", cnt_eof[1], 1);
    check("t5m_byte_cnt", bc[1], 2);
    check("t5m_byte_data", bd[1], 8'h4E);

    // Asynchronous reset in the middle of a symbol.
    clear_mon();
    start_frame();
    send_mask(4'b1000, 1'b0);
    Din = 1'b0;
    repeat (10) tick();
    #3;
    rst_n = 1'b0;
    #1;
    check("t6_rst_busy", bsy[0], 0);
    check("t6_rst_byte_data", bd[0], 0);
    check("t6_rst_byte_cnt", bc[0], 0);
    check("t6m_rst_busy", bsy[1], 0);
    Din = 1'b1;
    repeat (2) tick();
    rst_n = 1'b1;
    idle(4);
    check("t6_no_pulses", 32'(cnt_bv[0] + cnt_eof[0] + cnt_err[0]), 0);

    // New frame after reset, with a stray SOF during RX.
    clear_mon();
    exp_q.push_back(8'h63);
    start_frame();
    send_byte(8'h63, 1'b1);
    send_mask(4'b0000, 1'b0);
    idle(4);
    check("t7_bv_cnt", cnt_bv[0], 1);
    check("t7_byte_data", bd[0], 8'h63);
    check("t7_eof_cnt", cnt_eof[0], 1);
    check("t7_err_cnt", cnt_err[0], 0);
    check("t7_byte_cnt", bc[0], 1);
    check("exp_q_drained", exp_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/ppm4_frame_decoder.md
Name: ppm4_frame_decoder

Overview:
Consumes the SOF-detect pulse and raw 16x-oversampled PPM line, then decodes the 4-PPM data symbols that follow.
- 4 slots per symbol, 2 bits per symbol, 4 symbols per byte.
- Emits bytes with a one-cycle valid strobe.
- Detects end-of-frame and coding errors.
- Drives eof_rcv_out back to the upstream SOF detector's eof_rcv_in to re-arm it for the next frame.

Parameters:
SLOT_CLKS, 8, clk16 cycles per PPM slot (even, >=4).
START_DLY, 8, clk16 cycles from sof_rcv_in high to start of slot 0 of the first data symbol (>=1).
MAX_BYTES, 64, maximum bytes per frame before overflow error (<=127).

Ports:
clk16  in  1  oversampling clock.
rst_n  in  1  reset.
Din  in  1  raw PPM line, active-low pulses.
sof_rcv_in  in  1  one-cycle SOF-detected pulse from upstream.
byte_data  out  8  last decoded byte, held until next byte.
byte_valid  out  1  one-cycle strobe, byte_data new.
eof_rcv_out  out  1  one-cycle end-of-frame pulse (to upstream eof_rcv_in).
frame_err  out  1  one-cycle coding/overflow error pulse.
busy  out  1  high while not IDLE.
byte_cnt  out  7  bytes delivered in current frame.

Behaviour:
Reset and interface:
- Reset rst_n, asynchronous, active-low; clock clk16. All state updates on posedge clk16.
- All outputs, counters and registers reset to 0; FSM resets to IDLE.

Input conditioning:
- din_q <= !Din, registered once. All sampling uses din_q.

FSM states: IDLE, ALIGN, RX.
- IDLE: busy=0. When sof_rcv_in=1: go to ALIGN, dly_cnt=0, byte_cnt=0. Otherwise hold.
- ALIGN: dly_cnt increments. At dly_cnt==START_DLY-1: go to RX with slot_cnt=0, slot_idx=0, sym_idx=0, hits=0.
- RX counters:
  - slot_cnt counts 0..SLOT_CLKS-1 and wraps.
  - slot_idx (0..3) increments on the wrap; sym_idx (0..3) increments when slot_idx wraps.
  - At slot_cnt==SLOT_CLKS/2: hits[slot_idx] <= din_q (mid-slot sample).

Symbol evaluation (last cycle of the symbol: slot_idx==3, slot_cnt==SLOT_CLKS-1):
- Use hits, including the slot-3 sample. hits clears for the next symbol.
- One-hot hits: dibit = index of the set bit, written to shift_reg[2*sym_idx+1 : 2*sym_idx] (first symbol -> bits[1:0]).
  - If sym_idx==3: byte_data <= assembled byte, byte_valid=1 the next cycle, byte_cnt+1.
- hits==0 (empty symbol) = EOF:
  - eof_rcv_out=1 for one cycle; go to IDLE.
  - If sym_idx!=0, the partial byte is discarded and frame_err=1 in the same cycle.
- More than one hit: frame_err=1 and eof_rcv_out=1 in the same cycle (re-arms upstream); go to IDLE.
- Completing byte number MAX_BYTES+1: that byte is not emitted; frame_err=1, eof_rcv_out=1; go to IDLE.

Latency: byte_valid/eof_rcv_out/frame_err rise on the clock edge after the final slot's last cycle.

Boundary conditions:
- sof_rcv_in while in ALIGN or RX: ignored.
- Async reset mid-frame: immediate return to IDLE; no pulses emitted.
- byte_data is unchanged by EOF or error.
- byte_cnt holds its value in IDLE until the next SOF.
- Strobes are never asserted for more than one cycle.

Decomposition:
- Shared package ppm_pkg:
  - FSM state enum (IDLE/ALIGN/RX).
  - PPM_SLOTS=4, BITS_PER_SYM=2, SYMS_PER_BYTE=4.
  - One-hot-to-dibit function.
- One natural sub-module: ppm4_slot_timer (slot_cnt/slot_idx/sym_idx counters, mid-sample and end-of-symbol strobes).
- FSM and byte assembly stay in the top.

Test Plan:
- Defaults. sof_rcv_in pulse, then symbols with pulse in slots 3,0,2,1, then an empty symbol -> byte_valid once with byte_data=8'h63, byte_cnt=1, then eof_rcv_out one cycle, frame_err=0, busy falls.
- Two bytes 8'hA5 (slots 1,1,2,2) and 8'h00 (slots 0,0,0,0) then empty symbol -> two byte_valid strobes 128 cycles apart, byte_cnt=2, eof_rcv_out.
- Symbol with pulses in slots 0 and 2 -> frame_err and eof_rcv_out in the same cycle, no byte_valid, FSM IDLE.
- Empty symbol as the 3rd symbol of a byte -> eof_rcv_out and frame_err together, byte_data unchanged.
- MAX_BYTES=2, send 3 valid bytes -> 2 byte_valid strobes; on the 3rd byte's completion frame_err=1, eof_rcv_out=1, no 3rd strobe.
- Assert rst_n low mid-symbol -> all outputs 0 immediately; new SOF after release decodes 8'h63 correctly. Also a sof_rcv_in pulse during RX is ignored (byte still correct).
